// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples spi_clk/cs_n/mosi in the clk domain,
// deserialises MSB-first frames from mosi and serialises a queued reply on miso.
module spi_target #(
  parameter int unsigned FRAME_WIDTH = 8,
  parameter logic [7:0]  IDLE_FILL   = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_clk,
  input  logic                   cs_n,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [FRAME_WIDTH-1:0] tx_word,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [FRAME_WIDTH-1:0] rx_word,
  output logic                   rx_valid,
  output logic                   tx_underrun,
  output logic                   frame_abort
);

  localparam logic [FRAME_WIDTH-1:0] FILL_WORD = FRAME_WIDTH'(IDLE_FILL);
  localparam logic [3:0]             LAST_BIT  = 4'(FRAME_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev;
  logic                   sclk_s, cs_s, mosi_s, rise, fall;

  logic [FRAME_WIDTH-1:0] hold, shift_reg, rx_shift;
  logic [FRAME_WIDTH-1:0] load_word, tx_shifted, rx_next;
  logic                   hold_full, reload_pending, frame_done;
  logic [3:0]             bit_cnt;

  logic load, tx_shift, rx_shift_en, last_bit, abort, to_idle;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev;
  assign fall   = ~sclk_s & sclk_prev;

  assign tx_ready   = ~hold_full;
  assign load_word  = hold_full ? hold : FILL_WORD;
  assign tx_shifted = shift_reg << 1;
  assign rx_next    = (rx_shift << 1) | FRAME_WIDTH'(mosi_s);

  // Equal-depth synchronisers keep spi_clk, cs_n and mosi aligned to each other
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and per-cycle control strobes; cs_n deassertion outranks any spi_clk edge
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    tx_shift    = 1'b0;
    rx_shift_en = 1'b0;
    last_bit    = 1'b0;
    abort       = 1'b0;
    to_idle     = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          to_idle    = 1'b1;
          abort      = (bit_cnt != 4'd0);
          state_next = IDLE;
        end else if (rise) begin
          rx_shift_en = 1'b1;
          last_bit    = (bit_cnt == LAST_BIT);
        end else if (fall) begin
          if (reload_pending) load     = 1'b1;
          else                tx_shift = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: holding register, shifters, bit counter and output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      miso           <= 1'b1;
      hold           <= '0;
      hold_full      <= 1'b0;
      shift_reg      <= '0;
      rx_shift       <= '0;
      rx_word        <= '0;
      rx_valid       <= 1'b0;
      tx_underrun    <= 1'b0;
      frame_abort    <= 1'b0;
      bit_cnt        <= 4'd0;
      reload_pending <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      rx_valid    <= frame_done;
      frame_done  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= abort;

      if (frame_done) rx_word <= rx_shift;

      // A word accepted while a load happens lands in holding, not in this load
      if (tx_valid && !hold_full) begin
        hold      <= tx_word;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        shift_reg      <= load_word;
        miso           <= load_word[FRAME_WIDTH-1];
        tx_underrun    <= ~hold_full;
        reload_pending <= 1'b0;
      end

      if (tx_shift) begin
        shift_reg <= tx_shifted;
        miso      <= tx_shifted[FRAME_WIDTH-1];
      end

      if (rx_shift_en) begin
        rx_shift <= rx_next;
        if (last_bit) begin
          bit_cnt        <= 4'd0;
          frame_done     <= 1'b1;
          reload_pending <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

      if (to_idle) begin
        miso           <= 1'b1;
        bit_cnt        <= 4'd0;
        reload_pending <= 1'b0;
      end
    end
  end

endmodule
